// File: rtl/adder_pkg.sv
// Shared constants, types and helpers for the pipelined adder.
package adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [DEF_WIDTH-1:0] psum;
  } stage_rec_t;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit adder slice: s/co = a + b + ci.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  assign s     = total[W-1:0];
  assign co    = total[W];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES carry-chained slices, one slice per clock.
// Optional PIPELINED_ADDER_OVF_EN adds a registered signed-overflow output (ovf).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  // Handshake: a transfer happens on an edge where valid && ready. The whole
  // pipe advances together when the output slot is empty or being drained;
  // in_ready is that advance term, so upstream is stalled with the pipe.
  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LOW = (k + 1) * CHUNK;
    localparam int SKW = WIDTH - LOW;

    logic [CHUNK-1:0] a, b, s;
    logic             ci, co, vin, load;
    logic [LOW-1:0]   sum_in;
    logic             valid_q, valid_d;
    logic             carry_q, carry_d;
    logic [LOW-1:0]   sum_q, sum_d;

    if (k == 0) begin : g_head
      assign a      = x[CHUNK-1:0];
      assign b      = y[CHUNK-1:0];
      assign ci     = cin;
      assign vin    = in_valid;
      assign sum_in = s;
    end else begin : g_body
      assign a      = g_stage[k-1].g_skew.xs_q[CHUNK-1:0];
      assign b      = g_stage[k-1].g_skew.ys_q[CHUNK-1:0];
      assign ci     = g_stage[k-1].carry_q;
      assign vin    = g_stage[k-1].valid_q;
      assign sum_in = {s, g_stage[k-1].sum_q};
    end

    adder_slice #(.W(CHUNK)) u_slice (
      .a  (a),
      .b  (b),
      .ci (ci),
      .s  (s),
      .co (co)
    );

    // Data only loads with a valid beat so outputs hold their last result
    // while bubbles pass through.
    assign load = adv && vin;

    always_comb begin
      valid_d = adv ? vin : valid_q;
      carry_d = load ? co : carry_q;
      sum_d   = load ? sum_in : sum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (SKW > 0) begin : g_skew
      logic [SKW-1:0] xs_in, ys_in;
      logic [SKW-1:0] xs_q, xs_d, ys_q, ys_d;

      if (k == 0) begin : g_src0
        assign xs_in = x[WIDTH-1:CHUNK];
        assign ys_in = y[WIDTH-1:CHUNK];
      end else begin : g_srcn
        assign xs_in = g_stage[k-1].g_skew.xs_q[SKW+CHUNK-1:CHUNK];
        assign ys_in = g_stage[k-1].g_skew.ys_q[SKW+CHUNK-1:CHUNK];
      end

      always_comb begin
        xs_d = load ? xs_in : xs_q;
        ys_d = load ? ys_in : ys_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          xs_q <= '0;
          ys_q <= '0;
        end else begin
          xs_q <= xs_d;
          ys_q <= ys_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;

`ifdef PIPELINED_ADDER_OVF_EN
  // The top slice holds both operand MSBs, so overflow resolves in the last stage.
  logic ovf_q, ovf_d;
  logic a_msb, b_msb, s_msb;

  assign a_msb = g_stage[STAGES-1].a[CHUNK-1];
  assign b_msb = g_stage[STAGES-1].b[CHUNK-1];
  assign s_msb = g_stage[STAGES-1].s[CHUNK-1];

  always_comb begin
    ovf_d = ovf_q;
    if (g_stage[STAGES-1].load) ovf_d = (a_msb == b_msb) && (s_msb != a_msb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4); also covers
// ovf when built with PIPELINED_ADDER_OVF_EN.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x, y;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [17:0]      drv_exp;

  int n_cmp = 0;
  int n_bad = 0;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef PIPELINED_ADDER_OVF_EN
    .cout      (cout),
    .ovf       (ovf)
`else
    .cout      (cout)
`endif
  );

`ifndef PIPELINED_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic c);
    int u, sa, sb, ss;
    logic o;
    u  = int'(a) + int'(b) + int'(c);
    sa = $signed(a);
    sb = $signed(b);
    ss = sa + sb + int'(c);
    o  = (ss > 32767) || (ss < -32768);
    return {o, u[16], u[15:0]};
  endfunction

  // ---------------- scoreboard ----------------
  // mdl: result keyed by the pipe-advance count at which it was accepted;
  // it must show at the output after STAGES advances. exp_q: literal values.
  logic [17:0] mdl[int];
  logic [17:0] exp_q[$];
  int          adv_cnt = 0;

  always @(negedge clk) begin
    int          idx;
    logic        exp_v;
    logic [17:0] e, lit;
    if (!rst_n) begin
      mdl.delete();
      exp_q.delete();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
    end else begin
      idx   = adv_cnt - STAGES + 1;
      exp_v = mdl.exists(idx);
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      chk("in_ready", 32'(in_ready), 32'(!exp_v || out_ready));
      if (exp_v) begin
        e = mdl[idx];
        chk("model_sum", 32'(sum), 32'(e[15:0]));
        chk("model_cout", 32'(cout), 32'(e[16]));
`ifdef PIPELINED_ADDER_OVF_EN
        chk("model_ovf", 32'(ovf), 32'(e[17]));
`endif
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("lit_underflow", 32'd1, 32'd0);
          end else begin
            lit = exp_q.pop_front();
            chk("lit_sum", 32'(sum), 32'(lit[15:0]));
            chk("lit_cout", 32'(cout), 32'(lit[16]));
`ifdef PIPELINED_ADDER_OVF_EN
            chk("lit_ovf", 32'(ovf), 32'(lit[17]));
`endif
          end
          mdl.delete(idx);
        end
      end
      if (!exp_v || out_ready) begin
        adv_cnt++;
        if (in_valid) begin
          mdl[adv_cnt] = model(x, y, cin);
          exp_q.push_back(drv_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [17:0] e);
    bit ok;
    x        = a;
    y        = b;
    cin      = c;
    drv_exp  = e;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      x        = 16'($urandom_range(0, 65535));
      y        = 16'($urandom_range(0, 65535));
      cin      = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    cin       = 1'b0;
    drv_exp   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Back-to-back stream, then full-width carry ripple.
    send(16'hf0a0, 16'h0f0a, 1'b0, {1'b0, 1'b0, 16'hffaa});
    send(16'hffff, 16'hffff, 1'b0, {1'b0, 1'b1, 16'hfffe});
    send(16'h0000, 16'h0000, 1'b0, {1'b0, 1'b0, 16'h0000});
    send(16'h000c, 16'h0020, 1'b0, {1'b0, 1'b0, 16'h002c});
    send(16'hffff, 16'h0000, 1'b1, {1'b0, 1'b1, 16'h0000});
    send(16'h7fff, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000});
    send(16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000});
    send(16'h0001, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0002});
    idle(6);

    // Backpressure: fill, stall 5 cycles, release with a new op pending.
    send(16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555});
    send(16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000});
    send(16'h00ff, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0100});
    send(16'habcd, 16'h1111, 1'b0, {1'b0, 1'b0, 16'hbcde});
    out_ready = 1'b0;
    idle(5);
    out_ready = 1'b1;
    send(16'h7fff, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000});
    idle(6);

    // Bubbles: valid pattern 1,0,1.
    send(16'h0001, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0002});
    idle(1);
    send(16'h0fff, 16'h0001, 1'b1, {1'b0, 1'b0, 16'h1001});
    idle(6);

    // Reset with three ops in flight, one of them already at the output.
    send(16'h1111, 16'h1111, 1'b0, {1'b0, 1'b0, 16'h2222});
    send(16'h2222, 16'h2222, 1'b0, {1'b0, 1'b0, 16'h4444});
    send(16'h3333, 16'h3333, 1'b0, {1'b0, 1'b0, 16'h6666});
    idle(1);
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_sum", 32'(sum), 32'd0);
    chk("async_rst_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);
    send(16'h0005, 16'h0003, 1'b1, {1'b0, 1'b0, 16'h0009});
    idle(8);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("model_drained", 32'(mdl.num()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
